// File: rtl/video_pattern_gen.sv
// Test-pattern generator: gradient, colour bars, checkerboard or solid colour,
// aligned with the timing inputs. Define VIDEO_PATTERN_BORDER_EN for a white frame border.
module video_pattern_gen #(
  parameter int COLOR_BITS  = 8,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 9,
  parameter int H_ACTIVE    = 240,
  parameter int V_ACTIVE    = 320,
  parameter int PIPE_STAGES = 2,
  parameter int CHECK_LOG2  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode_sel,
  input  logic [3*COLOR_BITS-1:0] solid_color,
  input  logic [H_BITS-1:0]       pos_h,
  input  logic [V_BITS-1:0]       pos_v,
  input  logic                    active_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    active_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [7:0]              frame_cnt,
  output logic [1:0]              mode_active
);

  localparam int CB = COLOR_BITS;
  localparam int PW = 3 * COLOR_BITS;

  logic          origin;
  logic          origin_q;
  logic          frame_start;
  logic [7:0]    cnt_now;
  logic [1:0]    mode_now;
  logic [2:0]    bar_idx;
  logic [2:0]    bar_rgb;
  logic          check_white;
  logic [PW-1:0] pixel;
  logic [PW-1:0] pixel_gated;

  logic [PW-1:0]          rgb_pipe [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] act_pipe;
  logic [PIPE_STAGES-1:0] hs_pipe;
  logic [PIPE_STAGES-1:0] vs_pipe;

  function automatic logic [PW-1:0] expand(input logic [2:0] f);
    return {{CB{f[2]}}, {CB{f[1]}}, {CB{f[0]}}};
  endfunction

  // The frame-start pixel already uses the freshly loaded mode and count.
  assign origin      = active_in && (pos_h == '0) && (pos_v == '0);
  assign frame_start = origin && !origin_q;
  assign cnt_now     = frame_start ? frame_cnt + 8'd1 : frame_cnt;
  assign mode_now    = frame_start ? mode_sel : mode_active;

  // Bar thresholds fold to constants; positions past the last one stay in bar 7.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (32'(pos_h) >= 32'(k * H_ACTIVE / 8)) bar_idx = 3'(k);
    end
  end

  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  assign check_white = pos_h[CHECK_LOG2] ^ pos_v[CHECK_LOG2] ^ cnt_now[5];

  always_comb begin
    pixel = '0;
    case (mode_now)
      2'd0:    pixel = {CB'(pos_h) + CB'(cnt_now), CB'(pos_v), 1'b1, {(CB-1){1'b0}}};
      2'd1:    pixel = expand(bar_rgb);
      2'd2:    pixel = check_white ? '1 : '0;
      default: pixel = solid_color;
    endcase
  end

`ifdef VIDEO_PATTERN_BORDER_EN
  logic on_border;
  assign on_border = (pos_h == '0) || (pos_h == H_BITS'(H_ACTIVE - 1)) ||
                     (pos_v == '0) || (pos_v == V_BITS'(V_ACTIVE - 1));
  assign pixel_gated = !active_in ? '0 : (on_border ? '1 : pixel);
`else
  assign pixel_gated = active_in ? pixel : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      origin_q    <= 1'b0;
      frame_cnt   <= '0;
      mode_active <= '0;
      act_pipe    <= '0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
      for (int i = 0; i < PIPE_STAGES; i++) rgb_pipe[i] <= '0;
    end else begin
      origin_q <= origin;
      if (frame_start) begin
        frame_cnt   <= cnt_now;
        mode_active <= mode_sel;
      end
      rgb_pipe[0] <= pixel_gated;
      act_pipe[0] <= active_in;
      hs_pipe[0]  <= hsync_in;
      vs_pipe[0]  <= vsync_in;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        rgb_pipe[i] <= rgb_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  assign {red, green, blue} = rgb_pipe[PIPE_STAGES-1];
  assign active_out         = act_pipe[PIPE_STAGES-1];
  assign hsync_out          = hs_pipe[PIPE_STAGES-1];
  assign vsync_out          = vs_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: scenario tasks against a pixel-rule reference model,
// with expected outputs delayed through a queue.
module tb_video_pattern_gen;

  localparam int PS       = 2;
  localparam int H_ACTIVE = 240;
  localparam int V_ACTIVE = 320;

  logic        clk;
  logic        rst;
  logic [1:0]  mode_sel;
  logic [23:0] solid_color;
  logic [9:0]  pos_h;
  logic [8:0]  pos_v;
  logic        active_in, hsync_in, vsync_in;
  logic [7:0]  red, green, blue;
  logic        active_out, hsync_out, vsync_out;
  logic [7:0]  frame_cnt;
  logic [1:0]  mode_active;
  logic [26:0] obs;

  int checks = 0;
  int passed = 0;

  logic [26:0] exp_q[$];
  logic [26:0] e;
  logic        m_prev;
  logic [7:0]  m_cnt;
  logic [1:0]  m_mode;

  video_pattern_gen #(.PIPE_STAGES(PS)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .solid_color(solid_color),
    .pos_h(pos_h), .pos_v(pos_v), .active_in(active_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .red(red), .green(green), .blue(blue),
    .active_out(active_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_cnt(frame_cnt), .mode_active(mode_active)
  );

  assign obs = {red, green, blue, active_out, hsync_out, vsync_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] model_pixel(input logic [1:0] mode, input int cnt,
                                              input int h, input int v,
                                              input logic [23:0] sc, input logic a);
    logic [23:0] res;
    int idx;
    res = 24'h000000;
    case (mode)
      2'd0: res = {8'((h + cnt) % 256), 8'(v % 256), 8'h80};
      2'd1: begin
        idx = h * 8 / H_ACTIVE;
        if (idx > 7) idx = 7;
        case (idx)
          0:       res = 24'hFFFFFF;
          1:       res = 24'hFFFF00;
          2:       res = 24'h00FFFF;
          3:       res = 24'h00FF00;
          4:       res = 24'hFF00FF;
          5:       res = 24'hFF0000;
          6:       res = 24'h0000FF;
          default: res = 24'h000000;
        endcase
      end
      2'd2: res = (((h / 16) + (v / 16) + (cnt / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: res = sc;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) res = 24'hFFFFFF;
`endif
    if (!a) res = 24'h000000;
    return res;
  endfunction

  task automatic reset_model();
    m_prev = 1'b0;
    m_cnt  = 8'd0;
    m_mode = 2'd0;
    exp_q.delete();
    repeat (PS - 1) exp_q.push_back({24'h0, 3'b011});
  endtask

  task automatic drive(input logic [1:0] ms, input logic [23:0] sc, input int h, input int v,
                       input logic a, input logic hs, input logic vs);
    logic org;
    mode_sel = ms; solid_color = sc; pos_h = 10'(h); pos_v = 9'(v);
    active_in = a; hsync_in = hs; vsync_in = vs;
    @(posedge clk);
    org = a && h == 0 && v == 0;
    if (org && !m_prev) begin
      m_cnt  = m_cnt + 8'd1;
      m_mode = ms;
    end
    m_prev = org;
    exp_q.push_back({model_pixel(m_mode, int'(m_cnt), h, v, sc, a), a, hs, vs});
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; active_in = 1'b1; pos_h = '0; pos_v = '0;
    mode_sel = 2'd3; solid_color = 24'hFFFFFF; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({obs, frame_cnt, mode_active} !== {24'h0, 3'b011, 8'h00, 2'd0})
      $display("FAIL reset: got %h/%0d/%0d want 000000011/0/0", obs, frame_cnt, mode_active);
    else passed++;
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk) rst = 1'b1;
    reset_model();
  endtask

  task automatic test_gradient();
    int hs_t[9] = '{0, 1, 0, 1, 0, 1, 10, 11, 12};
    int vs_t[9] = '{0, 0, 0, 0, 0, 0, 5, 5, 5};
    for (int i = 0; i < 9; i++) begin
      drive(2'd0, 24'h0, hs_t[i], vs_t[i], 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL gradient step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 7) begin
        checks++;
        if ({red, green, blue} !== 24'h0D0580)
          $display("FAIL gradient_pixel: got %h want 0d0580", {red, green, blue});
        else passed++;
      end
    end
  endtask

  task automatic test_bars();
    int hs_t[15] = '{0, 30, 239, 0, 29, 60, 90, 120, 150, 180, 210, 240, 600, 1023, 31};
    for (int i = 0; i < 15; i++) begin
      drive(2'd1, 24'h0, hs_t[i], (i == 0) ? 0 : 7, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL bars step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 2 || i == 3) begin
        checks++;
        if ({red, green, blue} !== ((i == 2) ? 24'hFFFF00 : 24'h000000))
          $display("FAIL bars_edge step %0d: got %h", i, {red, green, blue});
        else passed++;
      end
    end
  endtask

  task automatic test_mode_hold();
    int hs_t[9] = '{0, 5, 6, 0, 0, 0, 0, 1, 2};
    int vs_t[9] = '{0, 100, 100, 0, 0, 0, 0, 0, 0};
    logic [7:0] c0;
    c0 = m_cnt;
    for (int i = 0; i < 9; i++) begin
      drive((i == 0) ? 2'd0 : 2'd2, 24'h0, hs_t[i], vs_t[i], 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL mode_hold step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 2 || i == 6) begin
        checks++;
        if ({frame_cnt, mode_active} !== ((i == 2) ? {c0 + 8'd1, 2'd0} : {c0 + 8'd2, 2'd2}))
          $display("FAIL mode_latch step %0d: got cnt %0d mode %0d", i, frame_cnt, mode_active);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] c_before;
    for (int n = 0; n < 260; n++) begin
      for (int j = 0; j < 2; j++) begin
        c_before = m_cnt;
        drive(2'd2, 24'h0, j, 0, 1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
          $display("FAIL wrap frame %0d: got %h/%0d/%0d want %h/%0d/%0d",
                   n, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
        else passed++;
        if (j == 0 && c_before == 8'd255) begin
          checks++;
          if (frame_cnt !== 8'd0) $display("FAIL cnt_wrap: got %0d want 0", frame_cnt);
          else passed++;
        end
        if (j == 1 && (m_cnt == 8'd31 || m_cnt == 8'd32)) begin
          checks++;
          if ({red, green, blue} !== ((m_cnt == 8'd31) ? 24'h000000 : 24'hFFFFFF))
            $display("FAIL checker_flip cnt %0d: got %h", m_cnt, {red, green, blue});
          else passed++;
        end
      end
    end
  endtask

  task automatic test_blank_sync();
    logic hs_t[7] = '{1, 1, 0, 1, 1, 1, 1};
    logic vs_t[7] = '{1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive(2'd3, 24'hFFFFFF, 20 + i, 40, 1'b0, hs_t[i], vs_t[i]);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL blank_sync step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 3) begin
        checks++;
        if ({red, green, blue, hsync_out} !== 25'h0)
          $display("FAIL hsync_delay: got rgb %h hsync %b want 000000 0", {red, green, blue}, hsync_out);
        else passed++;
      end
    end
  endtask

`ifdef VIDEO_PATTERN_BORDER_EN
  task automatic test_border();
    int hs_t[5] = '{0, 0, 100, 239, 5};
    int vs_t[5] = '{0, 50, 50, 50, 319};
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, 24'h000000, hs_t[i], vs_t[i], 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL border step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 2) begin
        checks++;
        if ({red, green, blue} !== 24'hFFFFFF)
          $display("FAIL border_pixel: got %h want ffffff", {red, green, blue});
        else passed++;
      end
    end
  endtask
`endif

  task automatic test_random();
    int h, v;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin h = 0; v = 0; end
      else begin h = $urandom_range(0, 1023); v = $urandom_range(0, 511); end
      drive(2'($urandom_range(0, 3)), 24'($urandom), h, v, $urandom_range(0, 7) != 0,
            $urandom_range(0, 5) != 0, $urandom_range(0, 9) != 0);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL random step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int hs_t[3] = '{0, 5, 6};
    for (int i = 0; i < 3; i++) begin
      drive(2'd3, 24'h123456, hs_t[i], (i == 0) ? 0 : 5, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL pre_reset step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({obs, frame_cnt, mode_active} !== {24'h0, 3'b011, 8'h00, 2'd0})
      $display("FAIL async_reset: got %h/%0d/%0d want 000000011/0/0", obs, frame_cnt, mode_active);
    else passed++;
    @(negedge clk) rst = 1'b1;
    reset_model();
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, 24'h123456, 7 + i, 5, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if ({obs, frame_cnt, mode_active} !== {e, m_cnt, m_mode})
        $display("FAIL post_reset step %0d: got %h/%0d/%0d want %h/%0d/%0d",
                 i, obs, frame_cnt, mode_active, e, m_cnt, m_mode);
      else passed++;
      if (i == 2) begin
        checks++;
        if ({red, green, blue, mode_active} !== {24'h080580, 2'd0})
          $display("FAIL post_reset_mode0: got %h mode %0d want 080580 0", {red, green, blue}, mode_active);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_gradient();
    test_bars();
    test_mode_hold();
    test_wrap();
    test_blank_sync();
`ifdef VIDEO_PATTERN_BORDER_EN
    test_border();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter COLOR_BITS, default 8, bits per colour channel (range 4..12).
REQ-002 Parameter H_BITS, default 10; V_BITS, default 9; widths of pos_h / pos_v.
REQ-003 Parameter H_ACTIVE, default 240; V_ACTIVE, default 320; active-region size in pixels.
REQ-004 Parameter PIPE_STAGES, default 2 (>=1), input-to-output latency in clk cycles.
REQ-005 Parameter CHECK_LOG2, default 4, log2 of checkerboard square size.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 mode_sel  input  2  requested pattern: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid.
REQ-009 solid_color  input  3*COLOR_BITS  {R,G,B} for mode 3.
REQ-010 pos_h / pos_v  input  H_BITS / V_BITS  current pixel position from timing generator.
REQ-011 active_in, hsync_in, vsync_in  input  1 each  timing generator active flag and syncs.
REQ-012 red, green, blue  output  COLOR_BITS each  registered pixel data.
REQ-013 active_out, hsync_out, vsync_out  output  1 each  inputs delayed to align with pixel data.
REQ-014 frame_cnt  output  8  frames started since reset.
REQ-015 mode_active  output  2  pattern currently being drawn.

Function
REQ-016 Frame start SHALL be the first cycle with active_in=1, pos_h=0, pos_v=0 after a cycle where that condition was false (edge-detected; held positions count once).
REQ-017 On frame start, mode_active SHALL load mode_sel and frame_cnt SHALL increment, wrapping 255->0; mode_sel changes mid-frame SHALL NOT affect the current frame.
REQ-018 Pattern selection on the frame-start cycle SHALL use the newly loaded mode.
REQ-019 Mode 0: red = low COLOR_BITS of (pos_h + frame_cnt), green = low COLOR_BITS of pos_v, blue = 1<<(COLOR_BITS-1); addition truncated, no saturation.
REQ-020 Mode 1: eight vertical bars, bar k spanning pos_h in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8), thresholds integer constants at elaboration, no runtime divider; colours k=0..7: white, yellow, cyan, green, magenta, red, blue, black (full = all ones).
REQ-021 Mode 2: white when pos_h[CHECK_LOG2] XOR pos_v[CHECK_LOG2] XOR frame_cnt[5] = 1, else black.
REQ-022 Mode 3: {red,green,blue} = solid_color sampled with the pixel.
REQ-023 When delayed active is 0, red/green/blue SHALL be 0 regardless of mode.
REQ-024 red/green/blue, active_out, hsync_out, vsync_out SHALL lag the corresponding inputs by exactly PIPE_STAGES cycles; no stage may bypass.
REQ-025 Positions at or beyond H_ACTIVE/V_ACTIVE with active_in=1 SHALL draw the pattern formula without error (bars: index clamped to 7).

Reset
REQ-026 While rst=0: red/green/blue=0, active_out=0, hsync_out=1, vsync_out=1, frame_cnt=0, mode_active=0, all pipeline stages and edge detector cleared.
REQ-027 Reset mid-frame SHALL discard in-flight pixels; after release outputs follow inputs after PIPE_STAGES cycles, mode 0 until next frame start.

Configuration
REQ-028 With VIDEO_PATTERN_BORDER_EN defined: pixels with pos_h in {0, H_ACTIVE-1} or pos_v in {0, V_ACTIVE-1} and active SHALL be white in every mode, same latency.
REQ-029 Without VIDEO_PATTERN_BORDER_EN: no border logic; pattern output unmodified at edges.

Verification
REQ-030 Defaults, mode_sel=0, frame_cnt=3, pos_h=10, pos_v=5, active_in=1 -> 2 cycles later red=0x0D, green=0x05, blue=0x80.
REQ-031 mode_sel=1, pos_h=30 then 239 -> red/green/blue = FF/FF/00 (yellow) then 00/00/00 (black).
REQ-032 mode_sel changes 0->2 at pos_v=100 -> mode_active stays 0 until next frame start, then 2; frame_cnt increments by 1 exactly once even if pos (0,0) held 4 cycles.
REQ-033 frame_cnt=255 at frame start -> frame_cnt=0; checkerboard pixel (0,0) inverts between frame_cnt 31 and 32.
REQ-034 active_in=0, mode 3, solid_color=0xFFFFFF -> RGB=0; hsync_in pulse low at t -> hsync_out low at t+PIPE_STAGES.
REQ-035 rst asserted mid-line with active_out=1 -> same cycle all outputs at REQ-026 values; border build: pixel (0,50) mode 3 solid 0x000000 -> white.
